dual_issue_sequencer: RTL and testbench
=======================================

Name: dual_issue_sequencer

Overview:
- Issue controller for the dual-issue decode stage: turns per-pair decode/hazard information into IF hold, per-slot ID/EX bubble and PC-redirect controls.
- Sequences split issue (slot0 now, slot1 next cycle), load-use stalls, and multi-cycle mult/div occupancy.
- Defers a slot0 branch redirect until its delay slot (slot1) has issued.
- Sits between decode/scheduler outputs and the IF/ID and ID/EX register control inputs.

Parameters:
- MD_LATENCY, 32, cycles a mult/div occupies EX; legal range 2..255.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- flush_in  input  1  exception/pipeline flush, highest priority
- valid0, valid1  input  1 each  IF/ID slot valid
- can_dual_issue  input  1  scheduler permits pair issue
- hazard0, hazard1  input  1 each  load-use hazard on slot0/slot1 operands
- is_branch  input  1  slot0 is a branch/jump
- jump_enable  input  1  slot0 branch taken
- jump_addr  input  32  slot0 target
- md_op0, md_op1  input  1 each  slot is mult/div
- if_hold  output  1  freeze PC and IF/ID
- bubble0, bubble1  output  1 each  flush the ID/EX slot this cycle
- redirect_en  output  1  load PC with redirect_addr
- redirect_addr  output  32  redirect target
- state_o  output  2  0=NORMAL, 1=SPLIT, 2=MD_WAIT

Behaviour:
- Reset (rst=0, async): state NORMAL, md counter 0, pend_redirect 0, pend_addr 0, counters 0.
- Outputs are combinational from state plus inputs.
- When not held: if_hold=0, bubble0=bubble1=0, redirect_en=0, redirect_addr=jump_addr.
- Slot issues = corresponding bubble is 0 and valid is 1.
- Any state, flush_in=1: bubble0=bubble1=1, if_hold=0, redirect_en=0. Next state NORMAL; counter and pend_redirect cleared. Overrides everything below.
- NORMAL, priority order:
  a) valid0 && hazard0: if_hold=1, bubble0=bubble1=1; stay. No redirect.
  b) valid1 && (!can_dual_issue || hazard1): issue slot0 only (bubble1=1, if_hold=1), then go to SPLIT. If is_branch, latch pend_redirect<=jump_enable and pend_addr<=jump_addr; redirect_en=0 this cycle. If md_op0, md wait is deferred: SPLIT sets counter on exit (see below).
  c) Otherwise (pair issue, or slot1 invalid): both valid slots issue; bubbleN=!validN; redirect_en=is_branch&&jump_enable. If md_op0||md_op1, go to MD_WAIT with counter<=MD_LATENCY-1.
- SPLIT: bubble0=1.
  - If hazard1: bubble1=1, if_hold=1; stay.
  - Else slot1 issues: if_hold=0, redirect_en=pend_redirect, redirect_addr=pend_addr; pend_redirect<=0.
  - Next state MD_WAIT (counter<=MD_LATENCY-1) if md_op1 or a deferred md_op0 is recorded; otherwise NORMAL.
- MD_WAIT: if_hold=1, bubble0=bubble1=1. Counter decrements each cycle; when it is 1, next state NORMAL. Total hold is MD_LATENCY-1 cycles after the issue cycle.
- valid0=0 in NORMAL: treated as slot0 bubble; hazard0 ignored; branch inputs ignored.
- A jump_enable while a hold condition (a) is active never produces a redirect.
- Reset mid-SPLIT or mid-MD_WAIT: immediate return to NORMAL; pending redirect discarded.

Optional Feature:
- Macro ISSUE_PERF_CNT_EN.
- Defined: adds outputs dual_cnt, single_cnt, stall_cnt (CNT_WIDTH each), counters wrap at 2^CNT_WIDTH.
  - dual_cnt: +1 per cycle with both slots issuing.
  - single_cnt: +1 per cycle with exactly one slot issuing.
  - stall_cnt: +1 per cycle with if_hold=1.
  - All three cleared on reset only, not on flush_in.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Pair valid, can_dual_issue=1, no hazards -> if_hold=0, bubble0=0, bubble1=0, state_o stays 0.
- valid0=1, hazard0=1 held 2 cycles -> if_hold=1, both bubbles=1 for 2 cycles; pair issues on the 3rd cycle.
- can_dual_issue=0, is_branch=1, jump_enable=1, jump_addr=0x00400100 -> cycle0: bubble1=1, redirect_en=0. Cycle1 (SPLIT): bubble0=1, bubble1=0, redirect_en=1, redirect_addr=0x00400100. Cycle2: state_o=0.
- MD_LATENCY=4, md_op0=1, pair issue -> issue cycle, then 3 cycles with if_hold=1 and both bubbles=1, then NORMAL.
- In SPLIT with pend_redirect=1, assert flush_in -> both bubbles=1, redirect_en=0, state_o=0 next cycle; later splits show no stale redirect.
- ISSUE_PERF_CNT_EN: 3 dual, 1 split pair, 2 stall cycles -> dual_cnt=3, single_cnt=2, stall_cnt=3 (2 stall cycles plus the split's first cycle).

Source files
------------

// File: rtl/dual_issue_sequencer_if.sv
// Issue-control bundle between the decode/scheduler side (master) and the dual-issue sequencer (slave).
// The perf counter outputs exist only when ISSUE_PERF_CNT_EN is defined.
interface dual_issue_sequencer_if #(
  parameter int CNT_WIDTH = 32
);
  // Valid/ready note: every signal here is a same-cycle level. The sequencer
  // answers the current decode pair combinationally, and if_hold acts as the
  // not-ready back-pressure. Decode must hold its pair stable while if_hold=1.
  logic        flush_in;
  logic        valid0;
  logic        valid1;
  logic        can_dual_issue;
  logic        hazard0;
  logic        hazard1;
  logic        is_branch;
  logic        jump_enable;
  logic [31:0] jump_addr;
  logic        md_op0;
  logic        md_op1;
  logic        if_hold;
  logic        bubble0;
  logic        bubble1;
  logic        redirect_en;
  logic [31:0] redirect_addr;
  logic [1:0]  state_o;
`ifdef ISSUE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] dual_cnt;
  logic [CNT_WIDTH-1:0] single_cnt;
  logic [CNT_WIDTH-1:0] stall_cnt;

  modport master (
    output flush_in, valid0, valid1, can_dual_issue, hazard0, hazard1,
           is_branch, jump_enable, jump_addr, md_op0, md_op1,
    input  if_hold, bubble0, bubble1, redirect_en, redirect_addr, state_o,
           dual_cnt, single_cnt, stall_cnt
  );
  modport slave (
    input  flush_in, valid0, valid1, can_dual_issue, hazard0, hazard1,
           is_branch, jump_enable, jump_addr, md_op0, md_op1,
    output if_hold, bubble0, bubble1, redirect_en, redirect_addr, state_o,
           dual_cnt, single_cnt, stall_cnt
  );
`else
  modport master (
    output flush_in, valid0, valid1, can_dual_issue, hazard0, hazard1,
           is_branch, jump_enable, jump_addr, md_op0, md_op1,
    input  if_hold, bubble0, bubble1, redirect_en, redirect_addr, state_o
  );
  modport slave (
    input  flush_in, valid0, valid1, can_dual_issue, hazard0, hazard1,
           is_branch, jump_enable, jump_addr, md_op0, md_op1,
    output if_hold, bubble0, bubble1, redirect_en, redirect_addr, state_o
  );
`endif

  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("CNT_WIDTH must be at least 1");
  end
endinterface

// File: rtl/dual_issue_sequencer.sv
// Dual-issue decode-stage issue controller: split issue, load-use stalls, mult/div occupancy, deferred branch redirect.
// Optional perf counters (dual/single/stall) are enabled by defining ISSUE_PERF_CNT_EN.
module dual_issue_sequencer #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_WIDTH  = 32
) (
  input logic                 clk,
  input logic                 rst,
  dual_issue_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_SPLIT   = 2'd1,
    ST_MD_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

  state_t      r_state;
  logic [7:0]  r_md_cnt;
  logic        r_pend_redirect;
  logic [31:0] r_pend_addr;
  logic        r_md_defer;

  logic        w_hz0;
  logic        w_split;
  logic        w_md_pair;
  logic        w_if_hold;
  logic        w_bubble0;
  logic        w_bubble1;
  logic        w_redirect_en;
  logic [31:0] w_redirect_addr;

  assign w_hz0     = bus.valid0 && bus.hazard0;
  assign w_split   = bus.valid1 && (!bus.can_dual_issue || bus.hazard1);
  assign w_md_pair = (bus.valid0 && bus.md_op0) || (bus.valid1 && bus.md_op1);

  always_comb begin
    w_if_hold       = 1'b0;
    w_bubble0       = 1'b0;
    w_bubble1       = 1'b0;
    w_redirect_en   = 1'b0;
    w_redirect_addr = bus.jump_addr;
    if (bus.flush_in) begin
      w_bubble0 = 1'b1;
      w_bubble1 = 1'b1;
    end else begin
      case (r_state)
        ST_NORMAL: begin
          if (w_hz0) begin
            w_if_hold = 1'b1;
            w_bubble0 = 1'b1;
            w_bubble1 = 1'b1;
          end else if (w_split) begin
            w_if_hold = 1'b1;
            w_bubble0 = !bus.valid0;
            w_bubble1 = 1'b1;
          end else begin
            w_bubble0     = !bus.valid0;
            w_bubble1     = !bus.valid1;
            w_redirect_en = bus.valid0 && bus.is_branch && bus.jump_enable;
          end
        end
        ST_SPLIT: begin
          // The delay slot is issuing now, so the branch held back from slot0 fires here.
          w_bubble0       = 1'b1;
          w_redirect_addr = r_pend_addr;
          if (bus.hazard1) begin
            w_if_hold = 1'b1;
            w_bubble1 = 1'b1;
          end else begin
            w_redirect_en = r_pend_redirect;
          end
        end
        ST_MD_WAIT: begin
          w_if_hold = 1'b1;
          w_bubble0 = 1'b1;
          w_bubble1 = 1'b1;
        end
        default: begin
          w_if_hold = 1'b1;
          w_bubble0 = 1'b1;
          w_bubble1 = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_NORMAL;
      r_md_cnt        <= 8'd0;
      r_pend_redirect <= 1'b0;
      r_pend_addr     <= 32'd0;
      r_md_defer      <= 1'b0;
    end else if (bus.flush_in) begin
      r_state         <= ST_NORMAL;
      r_md_cnt        <= 8'd0;
      r_pend_redirect <= 1'b0;
      r_md_defer      <= 1'b0;
    end else begin
      case (r_state)
        ST_NORMAL: begin
          if (w_hz0) begin
            r_state <= ST_NORMAL;
          end else if (w_split) begin
            r_state    <= ST_SPLIT;
            r_md_defer <= bus.valid0 && bus.md_op0;
            if (bus.valid0 && bus.is_branch) begin
              r_pend_redirect <= bus.jump_enable;
              r_pend_addr     <= bus.jump_addr;
            end
          end else if (w_md_pair) begin
            r_state  <= ST_MD_WAIT;
            r_md_cnt <= MD_LOAD;
          end
        end
        ST_SPLIT: begin
          if (!bus.hazard1) begin
            r_pend_redirect <= 1'b0;
            r_md_defer      <= 1'b0;
            // A mult/div in slot0 starts its occupancy only once slot1 has left ID.
            if ((bus.valid1 && bus.md_op1) || r_md_defer) begin
              r_state  <= ST_MD_WAIT;
              r_md_cnt <= MD_LOAD;
            end else begin
              r_state <= ST_NORMAL;
            end
          end
        end
        ST_MD_WAIT: begin
          if (r_md_cnt <= 8'd1) begin
            r_state  <= ST_NORMAL;
            r_md_cnt <= 8'd0;
          end else begin
            r_md_cnt <= r_md_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= ST_NORMAL;
        end
      endcase
    end
  end

  assign bus.if_hold       = w_if_hold;
  assign bus.bubble0       = w_bubble0;
  assign bus.bubble1       = w_bubble1;
  assign bus.redirect_en   = w_redirect_en;
  assign bus.redirect_addr = w_redirect_addr;
  assign bus.state_o       = r_state;

`ifdef ISSUE_PERF_CNT_EN
  logic                 w_issue0;
  logic                 w_issue1;
  logic [CNT_WIDTH-1:0] r_dual_cnt;
  logic [CNT_WIDTH-1:0] r_single_cnt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  assign w_issue0 = bus.valid0 && !w_bubble0;
  assign w_issue1 = bus.valid1 && !w_bubble1;

  // Counters survive flush_in on purpose; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dual_cnt   <= '0;
      r_single_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_issue0 && w_issue1) r_dual_cnt   <= r_dual_cnt + 1'b1;
      if (w_issue0 ^ w_issue1)  r_single_cnt <= r_single_cnt + 1'b1;
      if (w_if_hold)            r_stall_cnt  <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.dual_cnt   = r_dual_cnt;
  assign bus.single_cnt = r_single_cnt;
  assign bus.stall_cnt  = r_stall_cnt;
`endif

  if (MD_LATENCY < 2 || MD_LATENCY > 255) begin : g_bad_md_latency
    $error("MD_LATENCY must be in 2..255");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("CNT_WIDTH must be at least 1");
  end

endmodule

// File: tb/tb_dual_issue_sequencer.sv
// Directed bench for dual_issue_sequencer with MD_LATENCY=4; expected values are hand-computed.
// Counter checks run only when ISSUE_PERF_CNT_EN is defined.
module tb_dual_issue_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  dual_issue_sequencer_if #(.CNT_WIDTH(32)) bus ();

  dual_issue_sequencer #(
    .MD_LATENCY(4),
    .CNT_WIDTH (32)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic hold, input logic b0,
                         input logic b1, input logic [1:0] st);
    chk({tag, ".if_hold"}, 32'(bus.if_hold), 32'(hold));
    chk({tag, ".bubble0"}, 32'(bus.bubble0), 32'(b0));
    chk({tag, ".bubble1"}, 32'(bus.bubble1), 32'(b1));
    chk({tag, ".state"},   32'(bus.state_o), 32'(st));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.flush_in       = 1'b0;
    bus.valid0         = 1'b0;
    bus.valid1         = 1'b0;
    bus.can_dual_issue = 1'b1;
    bus.hazard0        = 1'b0;
    bus.hazard1        = 1'b0;
    bus.is_branch      = 1'b0;
    bus.jump_enable    = 1'b0;
    bus.jump_addr      = 32'h0;
    bus.md_op0         = 1'b0;
    bus.md_op1         = 1'b0;
  endtask

  task automatic set_pair(input logic cdi);
    bus.valid0         = 1'b1;
    bus.valid1         = 1'b1;
    bus.can_dual_issue = cdi;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic settle();
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    set_idle();
    rst = 1'b0;
    #2;
    chk("reset_state", 32'(bus.state_o), 32'd0);
    chk("reset_redirect", 32'(bus.redirect_en), 32'd0);
    do_reset();

    // Plain pair issue
    set_pair(1'b1);
    settle();
    chk_ctl("pair", 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    settle();
    chk_ctl("pair_next", 1'b0, 1'b0, 1'b0, 2'd0);
    tick();

    // Load-use stall on slot0 for two cycles; a taken branch must not redirect while held
    bus.hazard0     = 1'b1;
    bus.is_branch   = 1'b1;
    bus.jump_enable = 1'b1;
    bus.jump_addr   = 32'h0040_0040;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk_ctl("hz0", 1'b1, 1'b1, 1'b1, 2'd0);
      chk("hz0.redirect_en", 32'(bus.redirect_en), 32'd0);
      tick();
    end
    bus.hazard0 = 1'b0;
    settle();
    chk_ctl("hz0_release", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("hz0_release.redirect_en", 32'(bus.redirect_en), 32'd1);
    chk("hz0_release.redirect_addr", bus.redirect_addr, 32'h0040_0040);
    tick();
    set_idle();

    // valid0=0 ignores hazard0 and branch inputs
    bus.valid1      = 1'b1;
    bus.hazard0     = 1'b1;
    bus.is_branch   = 1'b1;
    bus.jump_enable = 1'b1;
    settle();
    chk_ctl("v0_off", 1'b0, 1'b1, 1'b0, 2'd0);
    chk("v0_off.redirect_en", 32'(bus.redirect_en), 32'd0);
    tick();
    set_idle();

    // Split issue with slot0 branch: redirect deferred to the delay slot
    set_pair(1'b0);
    bus.is_branch   = 1'b1;
    bus.jump_enable = 1'b1;
    bus.jump_addr   = 32'h0040_0100;
    settle();
    chk_ctl("split_c0", 1'b1, 1'b0, 1'b1, 2'd0);
    chk("split_c0.redirect_en", 32'(bus.redirect_en), 32'd0);
    tick();
    bus.is_branch   = 1'b0;
    bus.jump_enable = 1'b0;
    bus.jump_addr   = 32'h0000_dead;
    settle();
    chk_ctl("split_c1", 1'b0, 1'b1, 1'b0, 2'd1);
    chk("split_c1.redirect_en", 32'(bus.redirect_en), 32'd1);
    chk("split_c1.redirect_addr", bus.redirect_addr, 32'h0040_0100);
    tick();
    set_idle();
    settle();
    chk("split_c2.state", 32'(bus.state_o), 32'd0);
    tick();

    // Mult/div pair issue: MD_LATENCY-1 = 3 hold cycles
    set_pair(1'b1);
    bus.md_op0 = 1'b1;
    settle();
    chk_ctl("md_issue", 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_ctl("md_wait", 1'b1, 1'b1, 1'b1, 2'd2);
      tick();
    end
    settle();
    chk_ctl("md_done", 1'b0, 1'b1, 1'b1, 2'd0);
    tick();

    // Split with md_op0: slot1 waits on hazard1, then mult/div occupancy follows
    set_pair(1'b0);
    bus.md_op0 = 1'b1;
    settle();
    chk_ctl("split_md_c0", 1'b1, 1'b0, 1'b1, 2'd0);
    tick();
    bus.hazard1 = 1'b1;
    settle();
    chk_ctl("split_md_hz1", 1'b1, 1'b1, 1'b1, 2'd1);
    tick();
    bus.hazard1 = 1'b0;
    settle();
    chk_ctl("split_md_c2", 1'b0, 1'b1, 1'b0, 2'd1);
    tick();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_ctl("split_md_wait", 1'b1, 1'b1, 1'b1, 2'd2);
      tick();
    end
    settle();
    chk("split_md_done.state", 32'(bus.state_o), 32'd0);
    tick();

    // Flush in SPLIT discards the pending redirect
    set_pair(1'b0);
    bus.is_branch   = 1'b1;
    bus.jump_enable = 1'b1;
    bus.jump_addr   = 32'h0040_0200;
    tick();
    bus.flush_in = 1'b1;
    settle();
    chk_ctl("flush_split", 1'b0, 1'b1, 1'b1, 2'd1);
    chk("flush_split.redirect_en", 32'(bus.redirect_en), 32'd0);
    tick();
    bus.flush_in = 1'b0;
    set_idle();
    settle();
    chk("flush_after.state", 32'(bus.state_o), 32'd0);
    tick();
    set_pair(1'b0);
    settle();
    chk_ctl("nostale_c0", 1'b1, 1'b0, 1'b1, 2'd0);
    tick();
    settle();
    chk("nostale_c1.state", 32'(bus.state_o), 32'd1);
    chk("nostale_c1.redirect_en", 32'(bus.redirect_en), 32'd0);
    tick();
    set_idle();

    // Flush during MD_WAIT
    set_pair(1'b1);
    bus.md_op1 = 1'b1;
    tick();
    set_idle();
    settle();
    chk("flush_md.state_before", 32'(bus.state_o), 32'd2);
    tick();
    bus.flush_in = 1'b1;
    settle();
    chk_ctl("flush_md", 1'b0, 1'b1, 1'b1, 2'd2);
    tick();
    bus.flush_in = 1'b0;
    settle();
    chk("flush_md_after.state", 32'(bus.state_o), 32'd0);
    tick();

    // Asynchronous reset in the middle of MD_WAIT
    set_pair(1'b1);
    bus.md_op0 = 1'b1;
    tick();
    set_idle();
    #1;
    chk("areset.state_before", 32'(bus.state_o), 32'd2);
    rst = 1'b0;
    #1;
    chk("areset.state", 32'(bus.state_o), 32'd0);
    chk("areset.if_hold", 32'(bus.if_hold), 32'd0);
    tick();
    rst = 1'b1;
    tick();

`ifdef ISSUE_PERF_CNT_EN
    // 3 dual cycles, one split pair (2 single, 1 hold), 2 load-use stall cycles
    do_reset();
    set_pair(1'b1);
    repeat (3) tick();
    set_pair(1'b0);
    repeat (2) tick();
    set_idle();
    bus.valid0  = 1'b1;
    bus.hazard0 = 1'b1;
    repeat (2) tick();
    set_idle();
    bus.flush_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    settle();
    chk("perf.dual_cnt",   bus.dual_cnt,   32'd3);
    chk("perf.single_cnt", bus.single_cnt, 32'd2);
    chk("perf.stall_cnt",  bus.stall_cnt,  32'd3);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
